tcp_decoder: RTL and testbench

Receive-side counterpart of the TCP segment encoder. It consumes a TCP segment as a stream of 32-bit big-endian words, starting at the source/dest port word. It extracts the fixed header fields and the MSS and window-scale options, and forwards payload words downstream. It also verifies the TCP checksum over the pseudo-header, header, options and payload, and sits between the IP-layer receive path and the TCP connection logic.

---
 rtl/tcp_decoder_if.sv | 44 ++++
 rtl/tcp_decoder.sv | 238 +++++++++++++++++++++++
 tb/tb_tcp_decoder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_decoder_if.sv
// Segment-stream bus between the IP receive path (master) and the TCP decoder (slave).
// Carries the pseudo-header context, the word stream and every parsed result.
interface tcp_decoder_if;
    logic        start;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [15:0] len_in;
    logic [31:0] data;
    logic        data_av;

    logic [15:0] src_port;
    logic [15:0] dest_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [3:0]  data_offset;
    logic [5:0]  flags;
    logic [15:0] window;
    logic [15:0] checksum_rx;
    logic [15:0] urg_ptr;
    logic [15:0] mss;
    logic        mss_av;
    logic [7:0]  scale_wnd;
    logic        scale_av;
    logic [31:0] pkg_data;
    logic        wr_en;
    logic [15:0] len_out;
    logic        fin;
    logic        checksum_ok;
    logic        hdr_err;

    modport master (
        output start, src_ip, dest_ip, len_in, data, data_av,
        input  src_port, dest_port, seq_num, ack_num, data_offset, flags, window,
               checksum_rx, urg_ptr, mss, mss_av, scale_wnd, scale_av,
               pkg_data, wr_en, len_out, fin, checksum_ok, hdr_err
    );

    modport slave (
        input  start, src_ip, dest_ip, len_in, data, data_av,
        output src_port, dest_port, seq_num, ack_num, data_offset, flags, window,
               checksum_rx, urg_ptr, mss, mss_av, scale_wnd, scale_av,
               pkg_data, wr_en, len_out, fin, checksum_ok, hdr_err
    );
endinterface

// File: rtl/tcp_decoder.sv
// TCP segment receiver: parses header and MSS/window-scale options, forwards payload
// words and verifies the one's-complement checksum including the pseudo-header.
module tcp_decoder #(
    parameter int MAX_OPT_WORDS = 10
) (
    input  logic          clk,
    input  logic          reset,
    tcp_decoder_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_1, S_HDR_2, S_HDR_3, S_HDR_4, S_HDR_5, S_OPTION, S_DATA, S_FIN
    } state_t;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dest_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [3:0]  data_offset;
        logic [5:0]  flags;
        logic [15:0] window;
        logic [15:0] checksum_rx;
        logic [15:0] urg_ptr;
    } hdr_t;

    // 32-bit add with the carry wrapped back in; one wrap is always enough.
    function automatic logic [31:0] csum_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[31:0] + {31'd0, s[32]};
    endfunction

    state_t      state_q, state_d;
    hdr_t        hdr_q, hdr_d;
    logic [15:0] mss_q, mss_d;
    logic        mss_av_q, mss_av_d;
    logic [7:0]  scale_q, scale_d;
    logic        scale_av_q, scale_av_d;
    logic [31:0] pkg_q, pkg_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] len_out_q, len_out_d;
    logic [15:0] bytes_left_q, bytes_left_d;
    logic [3:0]  opt_cnt_q, opt_cnt_d;
    logic        fin_q, fin_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [31:0] sum_q, sum_d;

    logic [31:0] pseudo_sum;
    logic [15:0] hdr_bytes;
    logic        off_err;
    logic [31:0] pay_mask;
    logic [31:0] pay_word;
    logic [31:0] sum_add;
    logic [15:0] bl_next;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        pseudo_sum = csum_add(csum_add(bus.src_ip, bus.dest_ip), {16'h0006, bus.len_in});
        hdr_bytes  = {10'd0, bus.data[31:28], 2'b00};
        off_err    = (bus.data[31:28] < 4'd5)
                  || (32'(bus.data[31:28]) > 32'(5 + MAX_OPT_WORDS))
                  || (hdr_bytes > bus.len_in);

        // Big-endian: the first bytes of the stream sit in the high lanes.
        case (bytes_left_q)
            16'd1:   pay_mask = 32'hFF00_0000;
            16'd2:   pay_mask = 32'hFFFF_0000;
            16'd3:   pay_mask = 32'hFFFF_FF00;
            default: pay_mask = 32'hFFFF_FFFF;
        endcase
        pay_word = bus.data & pay_mask;
        bl_next  = (bytes_left_q > 16'd4) ? bytes_left_q - 16'd4 : 16'd0;
        sum_add  = csum_add(sum_q, (state_q == S_DATA) ? pay_word : bus.data);
    end

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        mss_d        = mss_q;
        mss_av_d     = mss_av_q;
        scale_d      = scale_q;
        scale_av_d   = scale_av_q;
        pkg_d        = pkg_q;
        wr_en_d      = 1'b0;
        len_out_d    = len_out_q;
        bytes_left_d = bytes_left_q;
        opt_cnt_d    = opt_cnt_q;
        fin_d        = fin_q;
        ok_d         = ok_q;
        err_d        = err_q;
        sum_d        = sum_q;

        case (state_q)
            S_IDLE, S_FIN: begin
                if (bus.start) begin
                    state_d    = S_HDR_1;
                    mss_av_d   = 1'b0;
                    scale_av_d = 1'b0;
                    err_d      = 1'b0;
                    fin_d      = 1'b0;
                    ok_d       = 1'b0;
                    sum_d      = pseudo_sum;
                end
            end
            S_HDR_1: if (bus.data_av) begin
                hdr_d.src_port  = bus.data[31:16];
                hdr_d.dest_port = bus.data[15:0];
                sum_d           = sum_add;
                state_d         = S_HDR_2;
            end
            S_HDR_2: if (bus.data_av) begin
                hdr_d.seq_num = bus.data;
                sum_d         = sum_add;
                state_d       = S_HDR_3;
            end
            S_HDR_3: if (bus.data_av) begin
                hdr_d.ack_num = bus.data;
                sum_d         = sum_add;
                state_d       = S_HDR_4;
            end
            S_HDR_4: if (bus.data_av) begin
                hdr_d.data_offset = bus.data[31:28];
                hdr_d.flags       = bus.data[21:16];
                hdr_d.window      = bus.data[15:0];
                err_d             = off_err;
                len_out_d         = off_err ? 16'd0 : bus.len_in - hdr_bytes;
                bytes_left_d      = len_out_d;
                sum_d             = sum_add;
                state_d           = S_HDR_5;
            end
            S_HDR_5: if (bus.data_av) begin
                hdr_d.checksum_rx = bus.data[31:16];
                hdr_d.urg_ptr     = bus.data[15:0];
                sum_d             = sum_add;
                if (err_q)
                    state_d = S_FIN;
                else if (hdr_q.data_offset > 4'd5) begin
                    state_d   = S_OPTION;
                    opt_cnt_d = hdr_q.data_offset - 4'd5;
                end else if (len_out_q != 16'd0)
                    state_d = S_DATA;
                else
                    state_d = S_FIN;
            end
            S_OPTION: if (bus.data_av) begin
                if (bus.data[31:16] == 16'h0204) begin
                    mss_d    = bus.data[15:0];
                    mss_av_d = 1'b1;
                end
                if (bus.data[31:8] == 24'h010303) begin
                    scale_d    = bus.data[7:0];
                    scale_av_d = 1'b1;
                end
                sum_d     = sum_add;
                opt_cnt_d = opt_cnt_q - 4'd1;
                if (opt_cnt_q == 4'd1)
                    state_d = (bytes_left_q != 16'd0) ? S_DATA : S_FIN;
            end
            S_DATA: if (bus.data_av) begin
                pkg_d        = pay_word;
                wr_en_d      = 1'b1;
                sum_d        = sum_add;
                bytes_left_d = bl_next;
                if (bl_next == 16'd0)
                    state_d = S_FIN;
            end
            default: state_d = S_IDLE;
        endcase

        // Verdict is latched on the edge that enters FIN so it is valid together with fin.
        fold1 = {1'b0, sum_d[31:16]} + {1'b0, sum_d[15:0]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
        if (state_d == S_FIN && state_q != S_FIN) begin
            fin_d = 1'b1;
            ok_d  = !err_d && (fold2 == 16'hFFFF || fold2 == 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hdr_q        <= '0;
            mss_q        <= '0;
            mss_av_q     <= 1'b0;
            scale_q      <= '0;
            scale_av_q   <= 1'b0;
            pkg_q        <= '0;
            wr_en_q      <= 1'b0;
            len_out_q    <= '0;
            bytes_left_q <= '0;
            opt_cnt_q    <= '0;
            fin_q        <= 1'b0;
            ok_q         <= 1'b0;
            err_q        <= 1'b0;
            sum_q        <= '0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            mss_q        <= mss_d;
            mss_av_q     <= mss_av_d;
            scale_q      <= scale_d;
            scale_av_q   <= scale_av_d;
            pkg_q        <= pkg_d;
            wr_en_q      <= wr_en_d;
            len_out_q    <= len_out_d;
            bytes_left_q <= bytes_left_d;
            opt_cnt_q    <= opt_cnt_d;
            fin_q        <= fin_d;
            ok_q         <= ok_d;
            err_q        <= err_d;
            sum_q        <= sum_d;
        end
    end

    assign bus.src_port    = hdr_q.src_port;
    assign bus.dest_port   = hdr_q.dest_port;
    assign bus.seq_num     = hdr_q.seq_num;
    assign bus.ack_num     = hdr_q.ack_num;
    assign bus.data_offset = hdr_q.data_offset;
    assign bus.flags       = hdr_q.flags;
    assign bus.window      = hdr_q.window;
    assign bus.checksum_rx = hdr_q.checksum_rx;
    assign bus.urg_ptr     = hdr_q.urg_ptr;
    assign bus.mss         = mss_q;
    assign bus.mss_av      = mss_av_q;
    assign bus.scale_wnd   = scale_q;
    assign bus.scale_av    = scale_av_q;
    assign bus.pkg_data    = pkg_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.len_out     = len_out_q;
    assign bus.fin         = fin_q;
    assign bus.checksum_ok = ok_q;
    assign bus.hdr_err     = err_q;

endmodule

// File: tb/tb_tcp_decoder.sv
// Table-driven bench for tcp_decoder: segments with bench-computed checksums,
// option parsing, payload masking, header errors and an asynchronous mid-segment reset.
module tb_tcp_decoder;

    logic clk;
    logic reset;
    tcp_decoder_if bus();

    tcp_decoder #(.MAX_OPT_WORDS(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       sip;
        logic [31:0]       dip;
        logic [15:0]       len;
        logic [15:0][31:0] w;
        logic [4:0]        n;
        logic [15:0]       gap;
        logic [3:0]        flip_w;
        logic [31:0]       flip_m;
        logic              e_err;
        logic [15:0]       e_len;
        logic [3:0]        e_nwr;
        logic [31:0]       e_pkg;
        logic              e_mav;
        logic [15:0]       e_mss;
        logic              e_sav;
        logic [7:0]        e_scl;
        logic              e_ok;
    } vec_t;

    vec_t        tv [6];
    int          checks;
    int          failures;
    int          nwr;
    logic [31:0] last_pkg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.wr_en) begin
            nwr++;
            last_pkg = bus.pkg_data;
        end
    endtask

    function automatic vec_t base(input logic [3:0] off, input logic [5:0] fl,
                                  input logic [15:0] len, input logic [4:0] n);
        vec_t v;
        v      = '0;
        v.sip  = 32'hC0A8_0001;
        v.dip  = 32'hC0A8_0002;
        v.len  = len;
        v.n    = n;
        v.w[0] = 32'h1234_0050;
        v.w[1] = 32'h0000_1000;
        v.w[2] = 32'hABCD_0001;
        v.w[3] = {off, 6'd0, fl, 16'h2000};
        v.w[4] = 32'h0000_0007;
        v.e_ok = 1'b1;
        return v;
    endfunction

    // Classic 16-bit one's-complement checksum; bytes past len are treated as zero.
    function automatic logic [15:0] calc_cks(input vec_t v);
        logic [31:0] s;
        logic [31:0] w;
        s = 32'(v.sip[31:16]) + 32'(v.sip[15:0]) + 32'(v.dip[31:16]) + 32'(v.dip[15:0])
          + 32'd6 + 32'(v.len);
        for (int i = 0; i < int'(v.n); i++) begin
            w = v.w[i];
            for (int b = 0; b < 4; b++)
                if (4 * i + b >= int'(v.len)) w[31 - 8 * b -: 8] = 8'h00;
            s = s + 32'(w[31:16]) + 32'(w[15:0]);
        end
        while (s[31:16] != 16'd0) s = 32'(s[31:16]) + 32'(s[15:0]);
        return ~s[15:0];
    endfunction

    task automatic run(input string tag, input vec_t vin);
        vec_t v;
        int   nwr_fin;
        v = vin;
        v.w[4][31:16] = calc_cks(v);
        v.w[v.flip_w] = v.w[v.flip_w] ^ v.flip_m;
        nwr      = 0;
        last_pkg = '0;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int i = 0; i < int'(v.n); i++) begin
            if (v.gap[i]) begin
                bus.data_av = 1'b0;
                cyc();
            end
            bus.data    = v.w[i];
            bus.data_av = 1'b1;
            cyc();
            if (i == int'(v.n) - 2) chk({tag, ".fin_early"}, bus.fin, 1'b0);
        end
        bus.data_av = 1'b0;
        chk({tag, ".fin"},       bus.fin,         1'b1);
        chk({tag, ".hdr_err"},   bus.hdr_err,     v.e_err);
        chk({tag, ".len_out"},   bus.len_out,     v.e_len);
        chk({tag, ".nwr"},       nwr,             v.e_nwr);
        chk({tag, ".pkg_data"},  last_pkg,        v.e_pkg);
        chk({tag, ".mss_av"},    bus.mss_av,      v.e_mav);
        chk({tag, ".scale_av"},  bus.scale_av,    v.e_sav);
        if (v.e_mav) chk({tag, ".mss"},       bus.mss,       v.e_mss);
        if (v.e_sav) chk({tag, ".scale_wnd"}, bus.scale_wnd, v.e_scl);
        chk({tag, ".cks_ok"},    bus.checksum_ok, v.e_ok);
        chk({tag, ".ports"},     {bus.src_port, bus.dest_port}, v.w[0]);
        chk({tag, ".seq"},       bus.seq_num,     v.w[1]);
        chk({tag, ".ack"},       bus.ack_num,     v.w[2]);
        chk({tag, ".offset"},    bus.data_offset, v.w[3][31:28]);
        chk({tag, ".flags"},     bus.flags,       v.w[3][21:16]);
        chk({tag, ".window"},    bus.window,      v.w[3][15:0]);
        chk({tag, ".cks_rx"},    bus.checksum_rx, v.w[4][31:16]);
        chk({tag, ".urg_ptr"},   bus.urg_ptr,     v.w[4][15:0]);
        // A stray word in FIN must be ignored.
        nwr_fin     = nwr;
        bus.data    = 32'hFFFF_FFFF;
        bus.data_av = 1'b1;
        cyc();
        bus.data_av = 1'b0;
        chk({tag, ".fin_hold"},  bus.fin,         1'b1);
        chk({tag, ".fin_nowr"},  nwr,             nwr_fin);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        nwr         = 0;
        last_pkg    = '0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.src_ip  = 32'hC0A8_0001;
        bus.dest_ip = 32'hC0A8_0002;
        bus.len_in  = 16'd0;
        bus.data    = '0;
        bus.data_av = 1'b0;

        tv[0] = base(4'd5, 6'h12, 16'd20, 5'd5);

        tv[1] = base(4'd7, 6'h10, 16'd28, 5'd7);
        tv[1].w[5]  = 32'h0204_05B4;
        tv[1].w[6]  = 32'h0103_0307;
        tv[1].gap   = 16'h0024;
        tv[1].e_mav = 1'b1;
        tv[1].e_mss = 16'd1460;
        tv[1].e_sav = 1'b1;
        tv[1].e_scl = 8'd7;

        tv[2] = base(4'd5, 6'h18, 16'd27, 5'd7);
        tv[2].w[5]  = 32'hDEAD_BEEF;
        tv[2].w[6]  = 32'h1122_33FF;
        tv[2].gap   = 16'h0040;
        tv[2].e_len = 16'd7;
        tv[2].e_nwr = 4'd2;
        tv[2].e_pkg = 32'h1122_3300;

        tv[3] = tv[2];
        tv[3].flip_w = 4'd5;
        tv[3].flip_m = 32'h0000_0100;
        tv[3].e_ok   = 1'b0;

        tv[4] = base(4'd4, 6'h10, 16'd20, 5'd5);
        tv[4].e_err = 1'b1;
        tv[4].e_ok  = 1'b0;

        tv[5] = base(4'd5, 6'h10, 16'd16, 5'd5);
        tv[5].e_err = 1'b1;
        tv[5].e_ok  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.wr_en",   bus.wr_en,       1'b0);
        chk("rst.fin",     bus.fin,         1'b0);
        chk("rst.cks_ok",  bus.checksum_ok, 1'b0);
        chk("rst.hdr_err", bus.hdr_err,     1'b0);
        chk("rst.fields",  {bus.src_port, bus.seq_num, bus.len_out}, 64'd0);
        reset = 1'b1;
        cyc();

        for (int k = 0; k < 6; k++) begin
            bus.src_ip  = tv[k].sip;
            bus.dest_ip = tv[k].dip;
            bus.len_in  = tv[k].len;
            run($sformatf("v%0d", k), tv[k]);
        end

        // Reset in the middle of a payload: everything drops at once, then a clean segment.
        bus.len_in = tv[2].len;
        nwr        = 0;
        bus.start  = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.data    = tv[2].w[i];
            bus.data_av = 1'b1;
            cyc();
        end
        bus.data_av = 1'b0;
        chk("mid.wr_en_before", bus.wr_en, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid.wr_en",  bus.wr_en,    1'b0);
        chk("mid.fin",    bus.fin,      1'b0);
        chk("mid.pkg",    bus.pkg_data, 32'd0);
        chk("mid.fields", {bus.src_port, bus.len_out, bus.ack_num[15:0]}, 64'd0);
        nwr = 0;
        cyc();
        cyc();
        chk("mid.no_wr_in_reset", nwr, 0);
        reset = 1'b1;
        cyc();
        chk("mid.idle_fin", bus.fin, 1'b0);
        bus.len_in = tv[0].len;
        run("post_rst", tv[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
